ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the operation and forwarded operands that the ID/EX register presents each cycle. It owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU in XLEN+1 cycles. It raises `stall` so the hazard logic can hold IF/ID and ID/EX, and insert a bubble, while a HI/LO consumer or a second mul/div waits.

## Interface
- `XLEN`, default 32: operand width; also the RUN iteration count.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: the EX-stage instruction is a mul/div/MTHI/MTLO op this cycle.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored (no effect).
- `a` in XLEN: rs operand, post-forwarding.
- `b` in XLEN: rt operand, post-forwarding.
- `rd_hilo` in 1: the EX-stage instruction is MFHI/MFLO.
- `flush` in 1: abort the in-flight operation.
- `busy` out 1: an operation is in flight (RUN or FIX).
- `stall` out 1: `busy & (start | rd_hilo)`; combinational.
- `done` out 1: one-cycle pulse after HI/LO is written by a mul/div.
- `hi` out XLEN: HI register.
- `lo` out XLEN: LO register.

## Operation
- **States:**
  - IDLE, RUN and FIX.
  - A 6-bit iteration counter, plus working registers: 2·XLEN accumulator, magnitude copies of the operands, and sign flags.
- **IDLE, accepting work:**
  - Inputs are sampled only in IDLE with `start=1` and `flush=0`.
  - MTHI/MTLO write `a` into hi/lo at that edge and stay in IDLE.
  - Mul/div ops latch |a| and |b| (raw values for the unsigned ops), record the result signs and go to RUN with counter=XLEN.
- **Multiply (RUN):** shift-add, one multiplier bit per cycle, LSB first.
- **Divide (RUN):** restoring division, one quotient bit per cycle, MSB first.
- **RUN → FIX:** the counter decrements each RUN cycle; when it reaches 1, go to FIX.
- **FIX:**
  - Apply sign correction, write hi/lo, go to IDLE and pulse `done` in the following cycle.
  - MULT negates the 2·XLEN product if sign(a)^sign(b).
  - DIV negates the quotient if sign(a)^sign(b) and the remainder if sign(a).
  - Results: lo = product[XLEN-1:0] / quotient; hi = product[2·XLEN-1:XLEN] / remainder.
- **Divide by zero:** the op runs the full length; the result is lo=all-ones and hi=a, for both signed and unsigned.
- **DIV 0x80000000 / −1:** lo=0x80000000, hi=0.
- **Abort:**
  - `flush` in RUN/FIX returns the unit to IDLE at that edge.
  - hi/lo are left unchanged and `done` is not pulsed.
  - `flush` in IDLE with `start` blocks acceptance.
- **Ops arriving while busy:** `start` is not accepted. `stall` holds the instruction upstream; it is accepted in the first cycle `busy=0`.
- **Reads:** MFHI/MFLO read `hi`/`lo` directly whenever `stall=0`.

## Timing
- **Reset:** hi=0, lo=0, busy=0, done=0, state IDLE, counter=0. Reset overrides flush/start and aborts any in-flight operation.
- **Latency from the accepting edge E0 (mul/div):**
  - `busy`=1 for cycles E0+1 … E0+XLEN+1 (33 cycles at XLEN=32).
  - hi/lo are updated at edge E0+XLEN+1.
  - `busy`=0 and `done`=1 in the cycle after E0+XLEN+1.
- **Back-to-back:** a new mul/div can be accepted in the `done` cycle; there is no dead cycle.
- **MTHI/MTLO while idle:** single cycle; the value is visible on `hi`/`lo` the cycle after acceptance.
- **`stall`:**
  - Combinational and glitch-free relative to registered `busy`.
  - It is never asserted while `busy=0`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 busy cycles, hi=0xFFFFFFFE, lo=0x00000001; `done` high for exactly 1 cycle.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Division cases:
  - DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Hazard sequence: MULT 5×6, then hold `rd_hilo=1` next cycle.
  - `stall`=1 for exactly the remaining busy cycles; in the `done` cycle lo=30 and `stall`=0.
  - Then MTLO a=9 presented while busy is accepted only after `busy` falls, and lo=9 the cycle after.
- Flush: preload hi=0x11, lo=0x22 via MTHI/MTLO; start DIVU 100/3; assert `flush` on RUN cycle 10.
  - Expect `busy`=0 next cycle, hi=0x11, lo=0x22, and no `done`.
- Reset on RUN cycle 5 of MULTU → the next cycle shows hi=lo=0, busy=done=stall=0; a subsequent MULTU 2×3 completes normally with lo=6.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            rd_hilo,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam logic [5:0] IterCnt = 6'(XLEN);

    localparam logic [2:0] OpMthi = 3'b100;
    localparam logic [2:0] OpMtlo = 3'b101;

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mb_q, mb_d;
    logic              is_div_q, is_div_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    // Operand decode for the accepting cycle
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[XLEN-1];
    assign b_neg     = signed_op & b[XLEN-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign b_zero    = (b == '0);

    // One multiply step: multiplier sits in the low half and is consumed LSB first
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring-divide step: remainder in the high half, quotient shifts into the low half
    logic [XLEN:0]     div_rem_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;

    assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff   = div_rem_sh - {1'b0, mb_q};
    assign div_ok     = ~div_diff[XLEN];
    assign div_next   = {div_ok ? div_diff[XLEN-1:0] : div_rem_sh[XLEN-1:0],
                         acc_q[XLEN-2:0], div_ok};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign prod_fix = neg_quo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mb_d      = mb_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    if (op == OpMthi) begin
                        hi_d = a;
                    end else if (op == OpMtlo) begin
                        lo_d = a;
                    end else if (!op[2]) begin
                        state_d   = StRun;
                        cnt_d     = IterCnt;
                        acc_d     = {{XLEN{1'b0}}, a_mag};
                        mb_d      = b_mag;
                        is_div_d  = op[1];
                        // Divide by zero keeps the all-ones quotient unnegated
                        neg_quo_d = (a_neg ^ b_neg) & ~(op[1] & b_zero);
                        neg_rem_d = a_neg & op[1];
                    end
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mb_q      <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mb_q      <= mb_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = busy & (start | rd_hilo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: arithmetic corners, hazards, flush and reset.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hilo;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_fail;

    ex_muldiv #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd_hilo (rd_hilo),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 3'b000; rd_hilo = 1'b1; flush = 1'b0;
        a = 32'h5; b = 32'h6;
        step();
        step();
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        start = 1'b0; rd_hilo = 1'b0;
        rst = 1'b0;
        step();
    endtask

    // Run one mul/div from idle and check latency, done pulse and results
    task automatic test_muldiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input string nm);
        int nb;
        int early_done;
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
        nb = 0;
        early_done = 0;
        while (busy && nb < 40) begin
            if (done) early_done++;
            nb++;
            step();
        end
        n_cmp++; if (nb !== 33) begin n_fail++; $display("FAIL %s busy_cycles got=%0d exp=33", nm, nb); end
        n_cmp++; if (early_done !== 0) begin n_fail++; $display("FAIL %s done_while_busy got=%0d exp=0", nm, early_done); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s done got=%b exp=1", nm, done); end
        n_cmp++; if (hi !== exp_hi) begin n_fail++; $display("FAIL %s hi got=%h exp=%h", nm, hi, exp_hi); end
        n_cmp++; if (lo !== exp_lo) begin n_fail++; $display("FAIL %s lo got=%h exp=%h", nm, lo, exp_lo); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got=%b exp=0", nm, done); end
    endtask

    task automatic test_hazard();
        int nb;
        int ns;
        int bad;
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        step();
        start = 1'b0; rd_hilo = 1'b1;
        nb = 0; ns = 0;
        while (busy && nb < 40) begin
            if (stall) ns++;
            nb++;
            step();
        end
        n_cmp++; if (ns !== 33) begin n_fail++; $display("FAIL hz_stall_cycles got=%0d exp=33", ns); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hz_stall_done got=%b exp=0", stall); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL hz_done got=%b exp=1", done); end
        n_cmp++; if (lo !== 32'd30) begin n_fail++; $display("FAIL hz_lo got=%h exp=1e", lo); end
        // Back-to-back: MULTU 2x2 accepted in the done cycle
        rd_hilo = 1'b0; start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd2;
        step();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        op = 3'b101; a = 32'd9;
        nb = 0; bad = 0;
        while (busy && nb < 40) begin
            if (!stall) bad++;
            nb++;
            step();
        end
        n_cmp++; if (nb !== 33) begin n_fail++; $display("FAIL b2b_busy_cycles got=%0d exp=33", nb); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mtlo_stall_gaps got=%0d exp=0", bad); end
        n_cmp++; if (lo !== 32'd4) begin n_fail++; $display("FAIL b2b_lo got=%h exp=4", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL b2b_hi got=%h exp=0", hi); end
        step();
        start = 1'b0;
        n_cmp++; if (lo !== 32'd9) begin n_fail++; $display("FAIL mtlo_lo got=%h exp=9", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush();
        int nd;
        start = 1'b1; op = 3'b100; a = 32'h11;
        step();
        n_cmp++; if (hi !== 32'h11) begin n_fail++; $display("FAIL mthi_hi got=%h exp=11", hi); end
        op = 3'b101; a = 32'h22;
        step();
        n_cmp++; if (lo !== 32'h22) begin n_fail++; $display("FAIL mtlo_lo2 got=%h exp=22", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mt_busy got=%b exp=0", busy); end
        op = 3'b011; a = 32'd100; b = 32'd3;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
        n_cmp++; if (hi !== 32'h11) begin n_fail++; $display("FAIL flush_hi got=%h exp=11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_fail++; $display("FAIL flush_lo got=%h exp=22", lo); end
        nd = 0;
        repeat (40) begin
            if (done) nd++;
            step();
        end
        n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL flush_done got=%0d exp=0", nd); end
        // Reserved op code has no effect
        start = 1'b1; op = 3'b110; a = 32'hDEAD; b = 32'h1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy got=%b exp=0", busy); end
        n_cmp++; if (hi !== 32'h11) begin n_fail++; $display("FAIL rsvd_hi got=%h exp=11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_fail++; $display("FAIL rsvd_lo got=%h exp=22", lo); end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1; rd_hilo = 1'b1; start = 1'b1; op = 3'b000;
        step();
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstrun_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstrun_lo got=%h exp=0", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstrun_done got=%b exp=0", done); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstrun_stall got=%b exp=0", stall); end
        rst = 1'b0; start = 1'b0; rd_hilo = 1'b0;
        step();
        test_muldiv(3'b001, 32'd2, 32'd3, 32'd0, 32'd6, "multu_2x3");
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0; rd_hilo = 1'b0; flush = 1'b0;
        test_reset();
        test_muldiv(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        test_muldiv(3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        test_muldiv(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        test_muldiv(3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_zero");
        test_muldiv(3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
        test_muldiv(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
        test_muldiv(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
        test_hazard();
        test_flush();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
